axi_demux_ar_gate: RTL and testbench
====================================

AXI_DEMUX_AR_GATE -- requirements
Module: axi_demux_ar_gate

Interface
REQ-001 SHALL have parameter AxiIdBits, default 2, meaning number of low AXI ID bits used for ordering lookup.
REQ-002 SHALL have parameter SelectWidth, default 2, meaning width of master-port select field.
REQ-003 SHALL have parameter StallCntWidth, default 16, meaning width of stall-cycle counter.
REQ-004 SHALL have clk_i  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have slv_ar_valid_i / slv_ar_ready_o  input/output  1 each  upstream AR handshake.
REQ-007 SHALL have slv_ar_id_i  input  AxiIdBits  request ID; slv_ar_select_i  input  SelectWidth  target master port.
REQ-008 SHALL have mst_ar_valid_o / mst_ar_ready_i  output/input  1 each  downstream AR handshake.
REQ-009 SHALL have mst_ar_id_o  output  AxiIdBits and mst_ar_select_o  output  SelectWidth  buffered request.
REQ-010 SHALL have lookup_axi_id_o  output  AxiIdBits  ID presented to ID-counter lookup.
REQ-011 SHALL have lookup_mst_select_i  input  SelectWidth, lookup_mst_select_occupied_i  input  1, full_i  input  1  ID-counter status.
REQ-012 SHALL have push_o  output  1, push_axi_id_o  output  AxiIdBits, push_mst_select_o  output  SelectWidth  ID-counter push.
REQ-013 SHALL have stall_cnt_o  output  StallCntWidth  cumulative ordering-stall cycles.

Function
REQ-014 SHALL hold one request in a single-entry buffer (id, select) and run FSM states EMPTY, CHECK, ISSUE.
REQ-015 SHALL drive slv_ar_ready_o = (state==EMPTY) | (state==ISSUE & mst_ar_ready_i).
REQ-016 SHALL, on slv_ar_valid_i & slv_ar_ready_o, capture slv_ar_id_i/slv_ar_select_i into the buffer and enter CHECK next cycle.
REQ-017 SHALL drive lookup_axi_id_o from buffered id at all times.
REQ-018 SHALL, in CHECK, compute grant = !full_i & (!lookup_mst_select_occupied_i | lookup_mst_select_i==buffered select).
REQ-019 SHALL, in CHECK with grant, assert push_o for exactly that cycle with push_axi_id_o/push_mst_select_o = buffer, and enter ISSUE.
REQ-020 SHALL, in CHECK without grant, stay in CHECK with push_o=0.
REQ-021 SHALL assert mst_ar_valid_o only in ISSUE, with mst_ar_id_o/mst_ar_select_o = buffer, stable until handshake.
REQ-022 SHALL never deassert mst_ar_valid_o before mst_ar_ready_i.
REQ-023 SHALL, in ISSUE on handshake, go EMPTY, or CHECK if a new slave handshake occurs the same cycle (buffer reloaded).
REQ-024 SHALL give minimum latency 2 cycles from slave handshake to mst_ar_valid_o, and sustained throughput 1 request per 2 cycles.
REQ-025 SHALL assert push_o at most once per accepted request; never in EMPTY or ISSUE.
REQ-026 SHALL drive push_axi_id_o/push_mst_select_o to buffer content regardless of push_o.

Reset
REQ-027 SHALL, on rst_i high at a clock edge, set state EMPTY, buffer 0, stall_cnt_o 0.
REQ-028 SHALL hold outputs while rst_i high: slv_ar_ready_o=0, mst_ar_valid_o=0, push_o=0, ids/selects 0.
REQ-029 SHALL discard an in-flight buffered request on reset mid-operation, without push.
REQ-030 SHALL, first cycle after rst_i low, be in EMPTY with slv_ar_ready_o=1.

Configuration
REQ-031 SHALL use macro AXI_DEMUX_AR_GATE_STALL_CNT_EN to compile the stall counter in or out.
REQ-032 SHALL, with macro defined, increment stall_cnt_o by 1 each CHECK cycle without grant, saturating at all-ones.
REQ-033 SHALL, with macro undefined, tie stall_cnt_o to 0 and instantiate no counter flops; all other behaviour identical.

Verification
REQ-034 SHALL cover: id=1,sel=2, occupied=0, full=0, ready=1 -> push_o in cycle 1, mst_ar_valid_o cycle 2, id=1,sel=2, one push.
REQ-035 SHALL cover: id=3,sel=1, occupied=1, lookup_sel=0 for 5 cycles then occupied=0 -> 5 stall cycles, stall_cnt_o=5 (macro on) or 0 (off), then issue.
REQ-036 SHALL cover: id=3,sel=1, occupied=1, lookup_sel=1 -> no stall, push in cycle 1.
REQ-037 SHALL cover: full_i=1 for 3 cycles in CHECK -> no push, no mst_ar_valid_o; grant on cycle 4.
REQ-038 SHALL cover: back-to-back requests, mst_ar_ready_i=1 -> slave accepts every 2 cycles, valid stable under ready=0 for 4 cycles.
REQ-039 SHALL cover: rst_i asserted in ISSUE -> mst_ar_valid_o=0 next cycle, no push, stall_cnt_o=0.

Source files
------------

// File: rtl/axi_demux_ar_gate.sv
// axi_demux_ar_gate: single-entry AR buffer that holds a read request until the
// ID-counter confirms ordering is safe (same ID not outstanding on another master
// port, counter not full), pushes the request into the ID counter, then issues it.
// Optional feature: define AXI_DEMUX_AR_GATE_STALL_CNT_EN to build a saturating
// counter of ordering-stall cycles; otherwise stall_cnt_o is tied to zero.
module axi_demux_ar_gate #(
    parameter int unsigned AxiIdBits     = 2,
    parameter int unsigned SelectWidth   = 2,
    parameter int unsigned StallCntWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     slv_ar_valid_i,
    output logic                     slv_ar_ready_o,
    input  logic [AxiIdBits-1:0]     slv_ar_id_i,
    input  logic [SelectWidth-1:0]   slv_ar_select_i,
    output logic                     mst_ar_valid_o,
    input  logic                     mst_ar_ready_i,
    output logic [AxiIdBits-1:0]     mst_ar_id_o,
    output logic [SelectWidth-1:0]   mst_ar_select_o,
    output logic [AxiIdBits-1:0]     lookup_axi_id_o,
    input  logic [SelectWidth-1:0]   lookup_mst_select_i,
    input  logic                     lookup_mst_select_occupied_i,
    input  logic                     full_i,
    output logic                     push_o,
    output logic [AxiIdBits-1:0]     push_axi_id_o,
    output logic [SelectWidth-1:0]   push_mst_select_o,
    output logic [StallCntWidth-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [AxiIdBits-1:0]   id_q;
    logic [SelectWidth-1:0] sel_q;
    logic                   slv_ready;
    logic                   slv_hs;
    logic                   grant;

    // Handshake and ordering-grant decode; outputs are forced idle while rst_i is high
    always_comb begin
        grant     = !full_i &&
                    (!lookup_mst_select_occupied_i || (lookup_mst_select_i == sel_q));
        slv_ready = !rst_i &&
                    ((state_q == EMPTY) || ((state_q == ISSUE) && mst_ar_ready_i));
        slv_hs    = slv_ar_valid_i && slv_ready;
    end

    // Next-state logic: EMPTY -> CHECK on accept, CHECK -> ISSUE on grant,
    // ISSUE drains to EMPTY or straight back to CHECK when a new request lands
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (slv_hs) state_d = CHECK;
            CHECK: if (grant) state_d = ISSUE;
            ISSUE: begin
                if (mst_ar_ready_i) state_d = slv_hs ? CHECK : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Request buffer, reloaded on every accepted upstream handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q  <= '0;
            sel_q <= '0;
        end else if (slv_hs) begin
            id_q  <= slv_ar_id_i;
            sel_q <= slv_ar_select_i;
        end
    end

    // Output drive: buffer content is visible on all ID/select outputs outside reset
    always_comb begin
        slv_ar_ready_o    = slv_ready;
        mst_ar_valid_o    = !rst_i && (state_q == ISSUE);
        push_o            = !rst_i && (state_q == CHECK) && grant;
        mst_ar_id_o       = rst_i ? '0 : id_q;
        mst_ar_select_o   = rst_i ? '0 : sel_q;
        lookup_axi_id_o   = rst_i ? '0 : id_q;
        push_axi_id_o     = rst_i ? '0 : id_q;
        push_mst_select_o = rst_i ? '0 : sel_q;
    end

`ifdef AXI_DEMUX_AR_GATE_STALL_CNT_EN
    logic [StallCntWidth-1:0] stall_cnt_q;

    // Saturating count of CHECK cycles spent waiting for an ordering grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == CHECK) && !grant && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + StallCntWidth'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_demux_ar_gate.sv
// Directed bench for axi_demux_ar_gate: single issue, ordering stall, same-port
// pass-through, full back-pressure, back-to-back throughput and mid-issue reset.
module tb_axi_demux_ar_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic        slv_valid, slv_ready;
    logic [1:0]  slv_id, slv_sel;
    logic        mst_valid, mst_ready;
    logic [1:0]  mst_id, mst_sel;
    logic [1:0]  lk_id, lk_sel;
    logic        lk_occ, full;
    logic        push;
    logic [1:0]  push_id, push_sel;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    int pushes = 0;
    int exp_stall5;

    axi_demux_ar_gate #(
        .AxiIdBits    (2),
        .SelectWidth  (2),
        .StallCntWidth(16)
    ) dut (
        .clk_i                       (clk),
        .rst_i                       (rst),
        .slv_ar_valid_i              (slv_valid),
        .slv_ar_ready_o              (slv_ready),
        .slv_ar_id_i                 (slv_id),
        .slv_ar_select_i             (slv_sel),
        .mst_ar_valid_o              (mst_valid),
        .mst_ar_ready_i              (mst_ready),
        .mst_ar_id_o                 (mst_id),
        .mst_ar_select_o             (mst_sel),
        .lookup_axi_id_o             (lk_id),
        .lookup_mst_select_i         (lk_sel),
        .lookup_mst_select_occupied_i(lk_occ),
        .full_i                      (full),
        .push_o                      (push),
        .push_axi_id_o               (push_id),
        .push_mst_select_o           (push_sel),
        .stall_cnt_o                 (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (push) pushes++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
`ifdef AXI_DEMUX_AR_GATE_STALL_CNT_EN
        exp_stall5 = 5;
`else
        exp_stall5 = 0;
`endif
        rst = 1'b1; slv_valid = 1'b0; slv_id = 2'd0; slv_sel = 2'd0;
        mst_ready = 1'b0; lk_sel = 2'd0; lk_occ = 1'b0; full = 1'b0;
        tick(); tick();
        chk("rst_slv_ready", 32'(slv_ready), 32'd0);
        chk("rst_mst_valid", 32'(mst_valid), 32'd0);
        chk("rst_push",      32'(push),      32'd0);
        chk("rst_stall",     32'(stall_cnt), 32'd0);
        rst = 1'b0; #1;
        chk("post_rst_ready", 32'(slv_ready), 32'd1);

        // single request, no conflict
        slv_valid = 1'b1; slv_id = 2'd1; slv_sel = 2'd2; mst_ready = 1'b1;
        tick(); slv_valid = 1'b0; #1;
        chk("t1_push",      32'(push),      32'd1);
        chk("t1_push_id",   32'(push_id),   32'd1);
        chk("t1_push_sel",  32'(push_sel),  32'd2);
        chk("t1_lk_id",     32'(lk_id),     32'd1);
        chk("t1_c1_valid",  32'(mst_valid), 32'd0);
        chk("t1_c1_ready",  32'(slv_ready), 32'd0);
        tick();
        chk("t1_valid",     32'(mst_valid), 32'd1);
        chk("t1_mst_id",    32'(mst_id),    32'd1);
        chk("t1_mst_sel",   32'(mst_sel),   32'd2);
        chk("t1_c2_push",   32'(push),      32'd0);
        tick();
        chk("t1_done_valid", 32'(mst_valid), 32'd0);
        chk("t1_done_ready", 32'(slv_ready), 32'd1);

        // ordering stall: same ID outstanding on another port for 5 cycles
        slv_valid = 1'b1; slv_id = 2'd3; slv_sel = 2'd1; lk_occ = 1'b1; lk_sel = 2'd0;
        tick(); slv_valid = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_push",  32'(push),      32'd0);
            chk("t2_stall_valid", 32'(mst_valid), 32'd0);
            tick();
        end
        lk_occ = 1'b0; #1;
        chk("t2_push",  32'(push),      32'd1);
        chk("t2_stall", 32'(stall_cnt), 32'(exp_stall5));
        tick();
        chk("t2_valid",  32'(mst_valid), 32'd1);
        chk("t2_mst_id", 32'(mst_id),    32'd3);
        tick();

        // same ID outstanding on the same port: no stall
        slv_valid = 1'b1; slv_id = 2'd3; slv_sel = 2'd1; lk_occ = 1'b1; lk_sel = 2'd1;
        tick(); slv_valid = 1'b0; #1;
        chk("t3_push",  32'(push), 32'd1);
        tick();
        chk("t3_valid", 32'(mst_valid), 32'd1);
        chk("t3_stall", 32'(stall_cnt), 32'(exp_stall5));
        tick();
        lk_occ = 1'b0;

        // ID counter full for 3 cycles
        full = 1'b1;
        slv_valid = 1'b1; slv_id = 2'd2; slv_sel = 2'd3;
        tick(); slv_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_full_push",  32'(push),      32'd0);
            chk("t4_full_valid", 32'(mst_valid), 32'd0);
            tick();
        end
        full = 1'b0; #1;
        chk("t4_push",     32'(push),     32'd1);
        chk("t4_push_sel", 32'(push_sel), 32'd3);
        tick();
        chk("t4_mst_sel", 32'(mst_sel), 32'd3);
        tick();

        // back-to-back requests, then downstream back-pressure
        slv_valid = 1'b1; slv_id = 2'd0; slv_sel = 2'd0; mst_ready = 1'b1; #1;
        chk("t5_ready0", 32'(slv_ready), 32'd1);
        tick(); slv_id = 2'd1; slv_sel = 2'd1; #1;
        chk("t5_c1_ready", 32'(slv_ready), 32'd0);
        chk("t5_c1_pid",   32'(push_id),   32'd0);
        tick();
        chk("t5_i1_id",    32'(mst_id),    32'd0);
        chk("t5_i1_ready", 32'(slv_ready), 32'd1);
        tick(); slv_id = 2'd2; slv_sel = 2'd2; #1;
        chk("t5_c2_ready", 32'(slv_ready), 32'd0);
        chk("t5_c2_pid",   32'(push_id),   32'd1);
        tick();
        chk("t5_i2_id",    32'(mst_id),    32'd1);
        slv_valid = 1'b0; mst_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_valid", 32'(mst_valid), 32'd1);
            chk("t5_hold_id",    32'(mst_id),    32'd1);
            chk("t5_hold_sel",   32'(mst_sel),   32'd1);
            chk("t5_hold_ready", 32'(slv_ready), 32'd0);
            tick();
        end
        mst_ready = 1'b1;
        tick();
        chk("t5_drain_valid", 32'(mst_valid), 32'd0);

        // reset while a request sits in ISSUE
        mst_ready = 1'b0;
        slv_valid = 1'b1; slv_id = 2'd1; slv_sel = 2'd3;
        tick(); slv_valid = 1'b0;
        tick();
        chk("t6_issue_valid", 32'(mst_valid), 32'd1);
        rst = 1'b1; #1;
        chk("t6_rst_valid", 32'(mst_valid), 32'd0);
        chk("t6_rst_push",  32'(push),      32'd0);
        tick();
        chk("t6_after_valid", 32'(mst_valid), 32'd0);
        chk("t6_after_stall", 32'(stall_cnt), 32'd0);
        chk("t6_after_push",  32'(push),      32'd0);
        rst = 1'b0; #1;
        chk("t6_ready",  32'(slv_ready), 32'd1);
        chk("t6_lk_id",  32'(lk_id),     32'd0);
        tick();
        chk("t6_idle_valid", 32'(mst_valid), 32'd0);
        chk("total_pushes", 32'(pushes), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
